// File: rtl/io_pkg.sv
// Shared I/O-space constants: bus widths, GPIO register indices and default bank select.
package io_pkg;

    localparam int unsigned IO_ADDR_W  = 8;
    localparam int unsigned IO_DATA_W  = 32;
    localparam int unsigned GPIO_W_MAX = 32;

    localparam logic [2:0] GPIO_BASE_DEF = 3'b001;

    typedef enum logic [2:0] {
        GPIO_OUT     = 3'd0,
        GPIO_DIR     = 3'd1,
        GPIO_IN      = 3'd2,
        GPIO_RISE_EN = 3'd3,
        GPIO_FALL_EN = 3'd4,
        GPIO_STATUS  = 3'd5,
        GPIO_OUT_SET = 3'd6,
        GPIO_OUT_CLR = 3'd7
    } gpio_reg_e;

endpackage

// File: rtl/io_gpio_bank_if.sv
// 8-bit-address / 32-bit-data I/O bus as seen by one peripheral.
interface io_gpio_bank_if;
    import io_pkg::*;

    logic [IO_ADDR_W-1:0] io_addr;
    logic                 io_en;
    logic                 io_we;
    logic [IO_DATA_W-1:0] io_data_write;
    logic [IO_DATA_W-1:0] io_data_read;

    modport master (output io_addr, io_en, io_we, io_data_write, input io_data_read);
    modport slave  (input io_addr, io_en, io_we, io_data_write, output io_data_read);

endinterface

// File: rtl/gpio_sync.sv
// W-wide, STAGES-deep synchroniser chain for asynchronous pin inputs.
module gpio_sync #(
    parameter int unsigned W      = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] chain_q [STAGES];

    always_ff @(posedge clk) begin
        if (!resetb) begin
            for (int i = 0; i < int'(STAGES); i++) chain_q[i] <= '0;
        end else begin
            chain_q[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) chain_q[i] <= chain_q[i-1];
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/io_gpio_bank.sv
// Parametrised GPIO bank with set/clear writes, synchronised inputs and edge interrupts.
// Edge-interrupt logic (RISE_EN, FALL_EN, STATUS, irq_gpio) is built only with GPIO_IRQ_EN.
module io_gpio_bank
    import io_pkg::*;
#(
    parameter int unsigned GPIO_W      = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [2:0]  BASE        = GPIO_BASE_DEF
) (
    input  logic              clk,
    input  logic              resetb,
    io_gpio_bank_if.slave     bus,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_dir,
    output logic              irq_gpio
);

    logic              sel;
    logic              wr;
    gpio_reg_e         idx;
    logic [GPIO_W-1:0] wd;
    logic [GPIO_W-1:0] out_q;
    logic [GPIO_W-1:0] dir_q;
    logic [GPIO_W-1:0] pin_s;
    logic [31:0]       rdata;
    logic              unused_ok;

    assign sel       = bus.io_en && (bus.io_addr[7:5] == BASE);
    assign wr        = sel && bus.io_we;
    assign idx       = gpio_reg_e'(bus.io_addr[4:2]);
    assign wd        = bus.io_data_write[GPIO_W-1:0];
    assign unused_ok = &{1'b0, bus.io_addr[1:0], bus.io_data_write};

    gpio_sync #(
        .W      (GPIO_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .resetb (resetb),
        .d      (gpio_in),
        .q      (pin_s)
    );

    always_ff @(posedge clk) begin
        if (!resetb) begin
            out_q <= '0;
            dir_q <= '0;
        end else if (wr) begin
            case (idx)
                GPIO_OUT:     out_q <= wd;
                GPIO_DIR:     dir_q <= wd;
                GPIO_OUT_SET: out_q <= out_q | wd;
                GPIO_OUT_CLR: out_q <= out_q & ~wd;
                default:      ;
            endcase
        end
    end

    assign gpio_out = out_q;
    assign gpio_dir = dir_q;

`ifdef GPIO_IRQ_EN
    logic [GPIO_W-1:0] rise_en_q;
    logic [GPIO_W-1:0] fall_en_q;
    logic [GPIO_W-1:0] status_q;
    logic [GPIO_W-1:0] pin_p;
    logic [GPIO_W-1:0] edge_c;
    logic [GPIO_W-1:0] clr_c;
    logic [GPIO_W-1:0] status_c;
    logic              irq_q;

    // New edges are OR-ed in after the W1C mask, so a coincident edge keeps its bit set.
    assign edge_c   = (pin_s & ~pin_p & rise_en_q) | (~pin_s & pin_p & fall_en_q);
    assign clr_c    = (wr && idx == GPIO_STATUS) ? wd : '0;
    assign status_c = (status_q & ~clr_c) | edge_c;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            pin_p     <= '0;
            irq_q     <= 1'b0;
        end else begin
            pin_p    <= pin_s;
            status_q <= status_c;
            irq_q    <= |status_c;
            if (wr && idx == GPIO_RISE_EN) rise_en_q <= wd;
            if (wr && idx == GPIO_FALL_EN) fall_en_q <= wd;
        end
    end

    assign irq_gpio = irq_q;
`else
    assign irq_gpio = 1'b0;
`endif

    // Zero-latency read mux; unselected or write-only indices return 0.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (idx)
                GPIO_OUT:     rdata = 32'(out_q);
                GPIO_DIR:     rdata = 32'(dir_q);
                GPIO_IN:      rdata = 32'(pin_s);
`ifdef GPIO_IRQ_EN
                GPIO_RISE_EN: rdata = 32'(rise_en_q);
                GPIO_FALL_EN: rdata = 32'(fall_en_q);
                GPIO_STATUS:  rdata = 32'(status_q);
`endif
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.io_data_read = rdata;

endmodule

// File: doc/io_gpio_bank.md
# io_gpio_bank

Parametrised general-purpose I/O bank on the 8-bit-address / 32-bit-data I/O bus. It succeeds the fixed 8-bit GPIO0/DIR0 pair with configurable width, atomic set/clear writes, synchronised pin input and per-bit edge interrupts. It sits beside the machine timer in the I/O space and drives one interrupt line to the core.

## Interface
Parameters:
- GPIO_W, 16: pin count, 1..32; register bits above GPIO_W read 0 and ignore writes.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.
- BASE, 3'b001: value of io_addr[7:5] selecting this bank (default window 0x20–0x3F).

Ports:
- clk  in  1  clock; all state updates on posedge.
- resetb  in  1  reset, synchronous, active-low.
- io_addr  in  8  byte address; [7:5] bank select, [4:2] register index, [1:0] ignored.
- io_en  in  1  bus access qualifier.
- io_we  in  1  write strobe, effective only with io_en.
- io_data_write  in  32  write data.
- io_data_read  out  32  read data, combinational.
- gpio_in  in  GPIO_W  asynchronous pin inputs.
- gpio_out  out  GPIO_W  output data register.
- gpio_dir  out  GPIO_W  direction, 1 = output.
- irq_gpio  out  1  level interrupt, OR of STATUS.

## Operation
- Selection: sel = io_en && io_addr[7:5] == BASE. A write happens when sel && io_we.
- Register map (index io_addr[4:2]):
  - 0 OUT: RW.
  - 1 DIR: RW.
  - 2 IN: RO, synchronised pins.
  - 3 RISE_EN: RW.
  - 4 FALL_EN: RW.
  - 5 STATUS: RW1C.
  - 6 OUT_SET: WO, OUT |= data.
  - 7 OUT_CLR: WO, OUT &= ~data.
- Reads: WO registers read 0. io_data_read = 0 when not sel, never X.
- Writes to IN are ignored.
- Edge detect: compare the last sync stage (s) with a one-cycle-delayed copy (p).
  - rise = s & ~p & RISE_EN; fall = ~s & p & FALL_EN.
  - STATUS |= rise | fall. Bits latch regardless of DIR.
- Simultaneous W1C and new edge on the same bit in one cycle: the set wins and the bit stays 1.
- irq_gpio = |STATUS, driven from registers (no combinational path from the bus).
- Reset values: OUT, DIR, RISE_EN, FALL_EN, STATUS, sync chain and p all 0. Hence gpio_out=0, gpio_dir=0 (all inputs), irq_gpio=0, io_data_read=0 when idle.
  - With the enables at 0, no spurious status can arise from sync-chain fill after reset.
- Reset mid-operation clears all state in the next cycle. Pending status is lost.

## Timing
- Register writes take effect at the clock edge that samples the write. gpio_out/gpio_dir change one edge after the bus write cycle.
- Read: zero-latency combinational from current register state. A read in the same cycle as a write returns the old value.
- Pin change sampled first at edge E0:
  - IN shows the new value after edge E0+SYNC_STAGES-1.
  - STATUS bit sets and irq_gpio rises after edge E0+SYNC_STAGES.
- Pulses shorter than one clock may be missed; this is accepted.
- W1C of the last pending bit drops irq_gpio after that write edge.

## Configuration
- Macro GPIO_IRQ_EN.
- Defined: RISE_EN, FALL_EN, STATUS, the delay register p and irq_gpio logic are present as above.
- Undefined: that logic is removed. Indices 3–5 read 0 and ignore writes. irq_gpio is tied 0. The port list is unchanged.

## Structure
- Shared package io_pkg: register-index constants (GPIO_OUT..GPIO_OUT_CLR), bank-select constant for BASE default, GPIO_W maximum (32).
- One sub-module, gpio_sync: GPIO_W-wide, SYNC_STAGES-deep flop chain with synchronous active-low reset to 0.

## Test plan
- Reset, then read all 8 indices: all 0; gpio_out=0, gpio_dir=0, irq_gpio=0.
- Write OUT=0x0000A5A5, then OUT_SET=0x00000F00, then OUT_CLR=0x00000005: gpio_out=0xAFA0; OUT reads 0x0000AFA0; OUT_SET/OUT_CLR read 0.
- Set RISE_EN=0x1, raise gpio_in[0] before edge E0: IN bit0=1 after E0+1, STATUS=0x1 and irq_gpio=1 after E0+2 (SYNC_STAGES=2). Write STATUS=0x1: irq_gpio=0 next cycle.
- FALL_EN=0x8000, drop gpio_in[15] in the same cycle as a W1C of bit 15 landing on the detect edge: STATUS bit 15 remains 1.
- Write with io_en=0, or with io_addr[7:5]≠BASE: no register changes, io_data_read=0. With GPIO_W=8, writing OUT=0xFFFFFFFF reads back 0x000000FF.
- Build without GPIO_IRQ_EN: writes to indices 3–5 read back 0; irq_gpio stays 0 under pin toggling.
